cu_sleep_monitor: RTL and testbench
===================================

CU_SLEEP_MONITOR -- requirements
Module: cu_sleep_monitor

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps per compute unit.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 16, maximum in-flight memory requests.
REQ-003 SHALL have parameter QUIET_CYCLES, default 4, consecutive idle cycles required before sleep.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-005 SHALL have port cu_rst_n_i  in  1  CU reset from the power controller (1 = CU released).
REQ-006 SHALL have port warp_active_i  in  NUM_WARPS  per-warp active mask.
REQ-007 SHALL have ports mem_req_valid_i, mem_req_ready_i  in  1  CU-to-L2 request handshake (observe only).
REQ-008 SHALL have ports mem_rsp_valid_i, mem_rsp_ready_i  in  1  L2-to-CU response handshake (observe only).
REQ-009 SHALL have port cu_sleep_req_o  out  1  single-cycle sleep request to the power controller.
REQ-010 SHALL have port cu_delay_sleep_o  out  1  sleep-deferral level (memory traffic in flight).
REQ-011 SHALL have port busy_o  out  1  monitor in WAIT, RUN or DRAIN.
REQ-012 SHALL have port outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight request count.
REQ-013 SHALL have port err_o  out  1  sticky counter overflow/underflow flag.

Function
REQ-014 SHALL implement FSM states MON_IDLE, MON_WAIT, MON_RUN, MON_DRAIN, MON_SLEEP.
REQ-015 SHALL go from MON_IDLE to MON_WAIT when cu_rst_n_i=1.
REQ-016 SHALL go from MON_WAIT to MON_RUN when |warp_active_i.
REQ-017 SHALL go from MON_RUN to MON_DRAIN when warp_active_i==0; the quiet counter SHALL be cleared on entry.
REQ-018 In MON_DRAIN, a cycle is quiet when warp_active_i==0, outstanding==0 and neither handshake fires; each quiet cycle SHALL increment the quiet counter, and each non-quiet cycle SHALL clear it.
REQ-019 In MON_DRAIN, |warp_active_i SHALL return the FSM to MON_RUN next cycle.
REQ-020 In MON_DRAIN, a quiet cycle with quiet counter == QUIET_CYCLES-1 SHALL move the FSM to MON_SLEEP.
REQ-021 cu_sleep_req_o SHALL be registered and high exactly the first cycle in MON_SLEEP.
REQ-022 MON_SLEEP SHALL be held until cu_rst_n_i=0.
REQ-023 cu_rst_n_i=0 in any state SHALL force MON_IDLE next cycle and clear the outstanding and quiet counters; err_o SHALL NOT be cleared.
REQ-024 A request handshake (valid&ready) SHALL increment outstanding, a response handshake SHALL decrement it, and both in the same cycle SHALL leave it unchanged.
REQ-025 Increment at MAX_OUTSTANDING SHALL hold the count and set err_o; decrement at 0 SHALL hold 0 and set err_o.
REQ-026 cu_delay_sleep_o SHALL be combinational: (outstanding!=0) | request handshake this cycle, forced 0 in MON_IDLE.
REQ-027 With QUIET_CYCLES=4, if warp_active_i goes to 0 at cycle t with no traffic, cu_sleep_req_o SHALL pulse at cycle t+5.

Reset
REQ-028 rst_ni=0 SHALL asynchronously set state MON_IDLE, counters 0, cu_sleep_req_o=0, err_o=0; cu_delay_sleep_o=0 and busy_o=0 SHALL follow.
REQ-029 Reset deassertion mid-traffic SHALL start counting from 0 and SHALL NOT flag err_o for responses to pre-reset requests until a new request is accepted (underflow at 0 ignored while in MON_IDLE/MON_WAIT).

Structure
REQ-030 The state enum SHALL live in a shared package cu_pwr_pkg, alongside the sleep-handshake widths used by the power controller.
REQ-031 The outstanding counter with saturation/error SHALL be a sub-module, cu_outstanding_cnt.
REQ-032 One instance per compute unit SHALL be used, with outputs wired to the power controller's per-CU sleep-request and delay-sleep inputs.

Verification
REQ-033 Scenario 1: release cu_rst_n_i, warp_active_i=4'b0011 for 10 cycles, then 0 with no traffic -> single cu_sleep_req_o pulse 5 cycles after the drop; busy_o falls at the pulse.
REQ-034 Scenario 2: 3 requests accepted, warps go idle, responses return 1 per 2 cycles -> cu_delay_sleep_o high until the last response; pulse 4 quiet cycles later; outstanding_o sequence 3,2,1,0.
REQ-035 Scenario 3: in MON_DRAIN with quiet counter at 2, warp 1 reactivates -> state MON_RUN, no pulse; a later idle requires 4 fresh quiet cycles.
REQ-036 Scenario 4: simultaneous req and rsp handshakes at outstanding=5 -> stays 5; 17 requests with MAX_OUTSTANDING=16 -> holds 16, err_o=1.
REQ-037 Scenario 5: cu_rst_n_i dropped in MON_RUN with outstanding=2 -> MON_IDLE next cycle, outstanding 0, cu_delay_sleep_o=0; async rst_ni mid-MON_SLEEP -> all outputs 0 immediately.

Source files
------------

// File: rtl/cu_pwr_pkg.sv
// Shared power-management types: monitor FSM encoding and the
// sleep-handshake widths seen by the power controller.
package cu_pwr_pkg;

    typedef enum logic [2:0] {
        MON_IDLE  = 3'd0,
        MON_WAIT  = 3'd1,
        MON_RUN   = 3'd2,
        MON_DRAIN = 3'd3,
        MON_SLEEP = 3'd4
    } mon_state_e;

    localparam int SLEEP_REQ_W   = 1;
    localparam int DELAY_SLEEP_W = 1;

    function automatic logic mon_busy(mon_state_e s);
        return (s == MON_WAIT) || (s == MON_RUN) || (s == MON_DRAIN);
    endfunction

endpackage

// File: rtl/cu_sleep_monitor_if.sv
// Observed CU<->L2 request/response handshake bundle.
// The monitor only listens, so it takes the slave view.
interface cu_sleep_monitor_if;

    logic req_valid;
    logic req_ready;
    logic rsp_valid;
    logic rsp_ready;

    modport master (
        output req_valid, req_ready,
        output rsp_valid, rsp_ready
    );

    modport slave (
        input req_valid, req_ready,
        input rsp_valid, rsp_ready
    );

endinterface

// File: rtl/cu_outstanding_cnt.sv
// In-flight memory request counter with saturation and a sticky
// error flag for overflow or (unless suppressed) underflow.
module cu_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 16,
    parameter int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ign_uf,
    cu_sleep_monitor_if.slave mem,
    output logic [CW-1:0]     count,
    output logic              err
);

    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

    logic inc;
    logic dec;

    assign inc = mem.req_valid & mem.req_ready;
    assign dec = mem.rsp_valid & mem.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= 1'b0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            if (count == CMAX) err <= 1'b1;
            else count <= count + 1'b1;
        end else if (dec && !inc) begin
            // responses to requests issued before a CU reset are expected
            if (count == '0) begin
                if (!ign_uf) err <= 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cu_sleep_monitor.sv
// Per-CU idle monitor: requests sleep after the warps and the memory
// path have been quiet for QUIET_CYCLES consecutive cycles.
module cu_sleep_monitor
    import cu_pwr_pkg::*;
#(
    parameter int NUM_WARPS       = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int QUIET_CYCLES    = 4,
    localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cu_rst_n_i,
    input  logic [NUM_WARPS-1:0]     warp_active_i,
    input  logic                     mem_req_valid_i,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_rsp_valid_i,
    input  logic                     mem_rsp_ready_i,
    output logic [SLEEP_REQ_W-1:0]   cu_sleep_req_o,
    output logic [DELAY_SLEEP_W-1:0] cu_delay_sleep_o,
    output logic                     busy_o,
    output logic [OW-1:0]            outstanding_o,
    output logic                     err_o
);

    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QUIET_CYCLES - 1);

    cu_sleep_monitor_if mem_if ();

    assign mem_if.req_valid = mem_req_valid_i;
    assign mem_if.req_ready = mem_req_ready_i;
    assign mem_if.rsp_valid = mem_rsp_valid_i;
    assign mem_if.rsp_ready = mem_rsp_ready_i;

    mon_state_e    state;
    mon_state_e    state_nx;
    logic [QW-1:0] quiet;
    logic [QW-1:0] quiet_nx;
    logic          go_sleep;
    logic          req_fire;
    logic          rsp_fire;
    logic          quiet_cyc;
    logic          any_warp;

    assign req_fire = mem_req_valid_i & mem_req_ready_i;
    assign rsp_fire = mem_rsp_valid_i & mem_rsp_ready_i;
    assign any_warp = |warp_active_i;

    assign quiet_cyc = ~any_warp & (outstanding_o == '0)
                     & ~req_fire & ~rsp_fire;

    cu_outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CW             (OW)
    ) u_cnt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (~cu_rst_n_i),
        .ign_uf((state == MON_IDLE) || (state == MON_WAIT)),
        .mem   (mem_if.slave),
        .count (outstanding_o),
        .err   (err_o)
    );

    always_comb begin
        state_nx = state;
        quiet_nx = quiet;
        go_sleep = 1'b0;
        unique case (state)
            MON_IDLE:  state_nx = MON_WAIT;
            MON_WAIT:  if (any_warp) state_nx = MON_RUN;
            MON_RUN: begin
                if (!any_warp) begin
                    state_nx = MON_DRAIN;
                    quiet_nx = '0;
                end
            end
            MON_DRAIN: begin
                if (any_warp) begin
                    state_nx = MON_RUN;
                end else if (quiet_cyc) begin
                    if (quiet == QLAST) begin
                        state_nx = MON_SLEEP;
                        go_sleep = 1'b1;
                    end else begin
                        quiet_nx = quiet + 1'b1;
                    end
                end else begin
                    quiet_nx = '0;
                end
            end
            MON_SLEEP: state_nx = MON_SLEEP;
            default:   state_nx = MON_IDLE;
        endcase
        if (!cu_rst_n_i) begin
            state_nx = MON_IDLE;
            quiet_nx = '0;
            go_sleep = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= MON_IDLE;
            quiet          <= '0;
            cu_sleep_req_o <= '0;
        end else begin
            state          <= state_nx;
            quiet          <= quiet_nx;
            cu_sleep_req_o <= go_sleep;
        end
    end

    assign busy_o = mon_busy(state);

    // a request accepted this cycle defers sleep before it reaches the count
    assign cu_delay_sleep_o = (state != MON_IDLE)
                            & ((outstanding_o != '0) | req_fire);

endmodule

// File: tb/tb_cu_sleep_monitor.sv
// Vector/scoreboard bench for cu_sleep_monitor.
module tb_cu_sleep_monitor;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       cu_rst_n;
    logic [3:0] warp;
    logic       sleep_req;
    logic       delay;
    logic       busy;
    logic [4:0] outs;
    logic       err;

    cu_sleep_monitor_if bus ();

    cu_sleep_monitor dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .cu_rst_n_i      (cu_rst_n),
        .warp_active_i   (warp),
        .mem_req_valid_i (bus.req_valid),
        .mem_req_ready_i (bus.req_ready),
        .mem_rsp_valid_i (bus.rsp_valid),
        .mem_rsp_ready_i (bus.rsp_ready),
        .cu_sleep_req_o  (sleep_req),
        .cu_delay_sleep_o(delay),
        .busy_o          (busy),
        .outstanding_o   (outs),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       crn;
        logic [3:0] warp;
        logic [1:0] q;
        logic [1:0] s;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(string name, logic [8:0] act, logic [8:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: sleep/dly/busy/outs/err got %b/%b/%b/%0d/%b required %b/%b/%b/%0d/%b",
                     name, act[8], act[7], act[6], act[5:1], act[0],
                     req[8], req[7], req[6], req[5:1], req[0]);
        end
    endtask

    // q/s are {valid,ready} for the request and response handshakes
    task automatic add(string tag, logic crn, logic [3:0] w,
                       logic [1:0] q, logic [1:0] s,
                       logic sl, logic dl, logic bz,
                       logic [4:0] o, logic er);
        vec_t v;
        v.tag  = tag;
        v.crn  = crn;
        v.warp = w;
        v.q    = q;
        v.s    = s;
        v.exp  = {sl, dl, bz, o, er};
        vecs.push_back(v);
    endtask

    task automatic run_vecs();
        vec_t v;
        vec_t e;
        int   i;
        i = 0;
        while (vecs.size() > 0) begin
            v = vecs.pop_front();
            @(negedge clk);
            cu_rst_n      = v.crn;
            warp          = v.warp;
            bus.req_valid = v.q[1];
            bus.req_ready = v.q[0];
            bus.rsp_valid = v.s[1];
            bus.rsp_ready = v.s[0];
            sb.push_back(v);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d]", e.tag, i),
                  {sleep_req, delay, busy, outs, err}, e.exp);
            i++;
        end
    endtask

    initial begin
        rst_ni        = 1'b0;
        cu_rst_n      = 1'b0;
        warp          = '0;
        bus.req_valid = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        #12;
        check("reset", {sleep_req, delay, busy, outs, err}, 9'b0);
        @(negedge clk);
        rst_ni = 1'b1;

        // idle after 10 busy cycles: pulse 5 cycles after the drop
        add("s1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add("s1", 1, 3, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) add("s1", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        add("s1", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        add("s1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("s1", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // warp reactivates with quiet count at 2
        add("s3", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("s3", 1, 2, 0, 0, 0, 0, 1, 0, 0);
        add("s3", 1, 2, 0, 0, 0, 0, 1, 0, 0);
        add("s3", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        add("s3", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        add("s3", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        add("s3", 1, 2, 0, 0, 0, 0, 1, 0, 0);
        add("s3", 1, 2, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) add("s3", 1, 0, 0, 0, 0, 0, 1, 0, 0);
        add("s3", 1, 0, 0, 0, 1, 0, 0, 0, 0);
        add("s3", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // simultaneous handshakes, partial handshakes, saturation
        add("s4", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add("s4", 1, 0, 2'b11, 0, 0, 1, 1, 5'(i), 0);
        add("s4", 1, 0, 2'b11, 2'b11, 0, 1, 1, 5, 0);
        add("s4", 1, 0, 2'b10, 2'b01, 0, 1, 1, 5, 0);
        for (int i = 0; i < 11; i++)
            add("s4", 1, 0, 2'b11, 0, 0, 1, 1, 5'(5 + i), 0);
        add("s4", 1, 0, 2'b11, 0, 0, 1, 1, 16, 0);
        add("s4", 1, 0, 0, 0, 0, 1, 1, 16, 1);
        add("s4", 0, 0, 0, 0, 0, 1, 1, 16, 1);

        // CU reset in RUN with two requests in flight
        add("s5", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("s5", 1, 1, 0, 0, 0, 0, 1, 0, 1);
        add("s5", 1, 1, 2'b11, 0, 0, 1, 1, 0, 1);
        add("s5", 1, 1, 2'b11, 0, 0, 1, 1, 1, 1);
        add("s5", 1, 1, 0, 0, 0, 1, 1, 2, 1);
        add("s5", 0, 1, 0, 0, 0, 1, 1, 2, 1);
        add("s5", 0, 1, 2'b11, 0, 0, 0, 0, 0, 1);
        add("s5", 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // three requests drained one response per two cycles
        add("s2", 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add("s2", 1, 1, 0, 0, 0, 0, 1, 0, 1);
        add("s2", 1, 1, 2'b11, 0, 0, 1, 1, 0, 1);
        add("s2", 1, 1, 2'b11, 0, 0, 1, 1, 1, 1);
        add("s2", 1, 1, 2'b11, 0, 0, 1, 1, 2, 1);
        add("s2", 1, 0, 0, 0, 0, 1, 1, 3, 1);
        add("s2", 1, 0, 0, 2'b11, 0, 1, 1, 3, 1);
        add("s2", 1, 0, 0, 0, 0, 1, 1, 2, 1);
        add("s2", 1, 0, 0, 2'b11, 0, 1, 1, 2, 1);
        add("s2", 1, 0, 0, 0, 0, 1, 1, 1, 1);
        add("s2", 1, 0, 0, 2'b11, 0, 1, 1, 1, 1);
        for (int i = 0; i < 4; i++) add("s2", 1, 0, 0, 0, 0, 0, 1, 0, 1);
        add("s2", 1, 0, 0, 0, 1, 0, 0, 0, 1);
        run_vecs();

        // async reset while the sleep pulse is high
        #1;
        rst_ni = 1'b0;
        #1;
        check("async_rst", {sleep_req, delay, busy, outs, err}, 9'b0);

        @(negedge clk);
        cu_rst_n      = 1'b0;
        warp          = '0;
        bus.req_valid = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst_ni        = 1'b1;

        // stale responses ignored in IDLE/WAIT, flagged in RUN
        add("uf", 0, 0, 0, 2'b11, 0, 0, 0, 0, 0);
        add("uf", 1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
        add("uf", 1, 0, 0, 2'b11, 0, 0, 1, 0, 0);
        add("uf", 1, 1, 0, 0, 0, 0, 1, 0, 0);
        add("uf", 1, 1, 0, 2'b11, 0, 0, 1, 0, 0);
        add("uf", 1, 1, 0, 0, 0, 0, 1, 0, 1);
        run_vecs();

        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
